shared_register_arbiter: RTL and testbench

- Round-robin arbiter and write sequencer for one shared W-bit data register.
- Up to N requesters compete for write access.
- The block grants one requester at a time, captures that requester's data into the register while it holds the grant, and enforces a maximum hold time so no requester starves the others.
- It sits between producer blocks and the shared flip-flop register bank.

---
 rtl/shared_register_arbiter_pkg.sv | 15 +
 rtl/data_reg_en.sv | 17 +
 rtl/shared_register_arbiter.sv | 114 +++++++++++
 tb/tb_shared_register_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/shared_register_arbiter_pkg.sv
// Shared types and width helpers for the round-robin shared-register arbiter.
package shared_register_arbiter_pkg;

    typedef enum logic {IDLE, GRANT} state_e;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Hold counter must represent 0..MAX_HOLD.
    function automatic int hold_cnt_w(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/data_reg_en.sv
// W-bit data register with load enable and async active-high clear.
module data_reg_en #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     q_o <= '0;
        else if (en_i) q_o <= d_i;
    end

endmodule

// File: rtl/shared_register_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a shared
// register, with a bounded hold time per grant.
module shared_register_arbiter
    import shared_register_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N-1:0]          req_i,
    input  logic [N*W-1:0]        wdata_i,
    output logic [N-1:0]          gnt_o,
    output logic [owner_w(N)-1:0] owner_o,
    output logic                  busy_o,
    output logic [W-1:0]          q_o,
    output logic                  q_valid_o
);

    localparam int OW = owner_w(N);
    localparam int CW = hold_cnt_w(MAX_HOLD);

    state_e        state_q;
    logic [N-1:0]  gnt_q;
    logic [OW-1:0] owner_q;
    logic [OW-1:0] last_q;
    logic [CW-1:0] hold_cnt_q;
    logic          q_valid_q;

    logic [OW-1:0] base_d;
    logic [OW-1:0] win_d;
    logic          load_d;
    logic          release_d;

    // First requester after 'last', wrapping; 'last' itself is checked last.
    function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] r, input logic [OW-1:0] last);
        logic [OW-1:0] pick;
        logic          found;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (int'(last) + k) % N;
            if (!found && r[j]) begin
                pick  = OW'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // On release the owner becomes the new 'last' in the same edge.
    always_comb begin
        base_d    = (state_q == GRANT) ? owner_q : last_q;
        win_d     = rr_pick(req_i, base_d);
        load_d    = (state_q == GRANT) && req_i[owner_q];
        release_d = !req_i[owner_q] || (hold_cnt_q == CW'(MAX_HOLD - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            last_q     <= OW'(N - 1);
            hold_cnt_q <= '0;
            q_valid_q  <= 1'b0;
        end else begin
            if (load_d) q_valid_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        state_q    <= GRANT;
                        gnt_q      <= N'(1) << win_d;
                        owner_q    <= win_d;
                        hold_cnt_q <= '0;
                    end
                end
                GRANT: begin
                    if (!release_d) begin
                        hold_cnt_q <= hold_cnt_q + CW'(1);
                    end else begin
                        last_q     <= owner_q;
                        hold_cnt_q <= '0;
                        if (|req_i) begin
                            gnt_q   <= N'(1) << win_d;
                            owner_q <= win_d;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                            owner_q <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    data_reg_en #(.W(W)) u_data_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (load_d),
        .d_i   (wdata_i[owner_q*W +: W]),
        .q_o   (q_o)
    );

    assign gnt_o     = gnt_q;
    assign owner_o   = owner_q;
    assign busy_o    = (state_q == GRANT);
    assign q_valid_o = q_valid_q;

endmodule

// File: tb/tb_shared_register_arbiter.sv
// Directed self-checking bench for shared_register_arbiter (N=4, W=8, MAX_HOLD=4).
module tb_shared_register_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   gnt;
    logic [1:0]     owner;
    logic           busy;
    logic [W-1:0]   q;
    logic           q_valid;

    int checks   = 0;
    int failures = 0;

    shared_register_arbiter #(.N(N), .W(W), .MAX_HOLD(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .wdata_i   (wdata),
        .gnt_o     (gnt),
        .owner_o   (owner),
        .busy_o    (busy),
        .q_o       (q),
        .q_valid_o (q_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        wdata[i*W +: W] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
        chk("rst_q", q, 0);
        chk("rst_qv", q_valid, 0);
        tick();
        rst = 1'b0;

        // Single request from reset
        req = 4'b0001;
        set_data(0, 8'hA5);
        tick();
        chk("single_gnt", gnt, 4'b0001);
        chk("single_busy", busy, 1);
        chk("single_q_pre", q, 0);
        tick();
        chk("single_q", q, 8'hA5);
        chk("single_qv", q_valid, 1);

        // All drop: returns to idle, q retained
        req = 4'b0000;
        tick();
        chk("drop_gnt", gnt, 0);
        chk("drop_owner", owner, 0);
        chk("drop_busy", busy, 0);
        chk("drop_q", q, 8'hA5);
        chk("drop_qv", q_valid, 1);

        // Hold limit: 4 cycles each, no idle bubble
        do_reset();
        req = 4'b0011;
        set_data(0, 8'h11);
        set_data(1, 8'h22);
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk($sformatf("hold_gnt_c%0d", c), gnt, (c <= 4 || c == 9) ? 4'b0001 : 4'b0010);
            if (c == 6) chk("hold_q_r1", q, 8'h22);
        end

        // Round-robin: each requester drops after one granted cycle
        do_reset();
        req = 4'b1111;
        tick();
        chk("rr_0", gnt, 4'b0001);
        req = 4'b1110; tick();
        chk("rr_1", gnt, 4'b0010);
        chk("rr_1_owner", owner, 1);
        req = 4'b1101; tick();
        chk("rr_2", gnt, 4'b0100);
        req = 4'b1011; tick();
        chk("rr_3", gnt, 4'b1000);
        chk("rr_3_owner", owner, 3);
        req = 4'b0111; tick();
        chk("rr_0_again", gnt, 4'b0001);

        // Early release: requester 2 drops after 2 cycles, 3 waiting
        do_reset();
        req = 4'b0100;
        set_data(2, 8'h5A);
        set_data(3, 8'hC3);
        tick();
        chk("early_gnt2", gnt, 4'b0100);
        chk("early_owner2", owner, 2);
        tick();
        chk("early_q1", q, 8'h5A);
        req = 4'b1100;
        set_data(2, 8'h77);
        tick();
        chk("early_q2", q, 8'h77);
        chk("early_still2", gnt, 4'b0100);
        req = 4'b1000;
        set_data(2, 8'h99);
        tick();
        chk("early_gnt3", gnt, 4'b1000);
        chk("early_q_hold", q, 8'h77);
        tick();
        chk("early_q3", q, 8'hC3);
        req = 4'b0000;
        tick();
        chk("early_idle", busy, 0);
        chk("early_idle_q", q, 8'hC3);

        // Async reset mid-grant
        req = 4'b0100;
        set_data(2, 8'h3C);
        tick();
        chk("ar_gnt", gnt, 4'b0100);
        tick();
        chk("ar_q", q, 8'h3C);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_gnt0", gnt, 0);
        chk("ar_q0", q, 0);
        chk("ar_qv0", q_valid, 0);
        chk("ar_busy0", busy, 0);
        req = 4'b1111;
        tick();
        chk("ar_held", gnt, 0);
        #2;
        rst = 1'b0;
        tick();
        chk("ar_first", gnt, 4'b0001);
        chk("ar_first_owner", owner, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
